// File: rtl/demux_frame_ctrl_pkg.sv
// Shared state encoding and widths for the demux frame controller.
package demux_pkg;

  localparam int ADDR_W = 2;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

endpackage

// File: rtl/demux_frame_ctrl_if.sv
// Serial frame input and demux-side outputs of the frame controller.
interface demux_frame_if;
  import demux_pkg::*;

  logic              ser_in;
  logic              start;
  logic              dout;
  logic [ADDR_W-1:0] sel;
  logic              dout_valid;
  logic              busy;
  logic              frame_done;
  logic              start_err;
  logic              parity_err;

  modport master (
    output ser_in, start,
    input  dout, sel, dout_valid, busy, frame_done, start_err, parity_err
  );

  modport slave (
    input  ser_in, start,
    output dout, sel, dout_valid, busy, frame_done, start_err, parity_err
  );

endinterface

// File: rtl/demux1_4.sv
// 1:4 demux stage: routes din to the output chosen by sel, others held low.
module demux1_4
  import demux_pkg::*;
(
  input  logic              din,
  input  logic [ADDR_W-1:0] sel,
  output logic              out1,
  output logic              out2,
  output logic              out3,
  output logic              out4
);

  assign out1 = din & (sel == 2'd0);
  assign out2 = din & (sel == 2'd1);
  assign out3 = din & (sel == 2'd2);
  assign out4 = din & (sel == 2'd3);

endmodule

// File: rtl/demux_frame_ctrl.sv
// Serial frame controller for demux1_4: 2-bit address then PAYLOAD_LEN bits.
// Define DEMUX_FRAME_PARITY_EN to add a trailing even-parity bit and parity_err.
module demux_frame_ctrl
  import demux_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_frame_if.slave bus
);

  localparam logic [7:0] LAST = 8'(PAYLOAD_LEN - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] sel_q, sel_nxt;
  logic              dout_q, dout_nxt;
  logic              valid_q, valid_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              serr_q, serr_nxt;
`ifdef DEMUX_FRAME_PARITY_EN
  logic              par_acc, par_nxt;
  logic              perr_q, perr_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    sel_nxt   = sel_q;
    dout_nxt  = 1'b0;
    valid_nxt = 1'b0;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    serr_nxt  = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
    par_nxt   = par_acc;
    perr_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        // busy re-arms here so a back-to-back start keeps it high
        busy_nxt = bus.start;
        if (bus.start) begin
          addr_nxt[1] = bus.ser_in;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        serr_nxt    = bus.start;
        addr_nxt[0] = bus.ser_in;
        sel_nxt     = {addr[1], bus.ser_in};
        cnt_nxt     = 8'd0;
        state_nxt   = DATA;
`ifdef DEMUX_FRAME_PARITY_EN
        par_nxt     = 1'b0;
`endif
      end
      DATA: begin
        serr_nxt  = bus.start;
        dout_nxt  = bus.ser_in;
        valid_nxt = 1'b1;
        cnt_nxt   = cnt + 8'd1;
`ifdef DEMUX_FRAME_PARITY_EN
        par_nxt   = par_acc ^ bus.ser_in;
        if (cnt == LAST) state_nxt = PAR;
`else
        if (cnt == LAST) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
`ifdef DEMUX_FRAME_PARITY_EN
      PAR: begin
        serr_nxt  = bus.start;
        done_nxt  = 1'b1;
        perr_nxt  = par_acc ^ bus.ser_in;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      addr    <= '0;
      sel_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr    <= addr_nxt;
      sel_q   <= sel_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      serr_q  <= serr_nxt;
`ifdef DEMUX_FRAME_PARITY_EN
      par_acc <= par_nxt;
      perr_q  <= perr_nxt;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel        = sel_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.start_err  = serr_q;
`ifdef DEMUX_FRAME_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// Directed bench for demux_frame_ctrl (PAYLOAD_LEN 8 and 2) feeding demux1_4.
module tb_demux_frame_ctrl;
  import demux_pkg::*;

`ifdef DEMUX_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_frame_if bus8 ();
  demux_frame_if bus2 ();
  logic out1, out2, out3, out4;

  demux_frame_ctrl #(.PAYLOAD_LEN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  demux_frame_ctrl #(.PAYLOAD_LEN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  demux1_4 dmx (.din(bus8.dout), .sel(bus8.sel), .out1(out1), .out2(out2), .out3(out3), .out4(out4));

  typedef struct packed {
    logic       start;
    logic       ser;
    logic       dout;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
    logic       serr;
    logic       perr;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] cur_sel;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [11:0] obs8();
    return {bus8.dout, bus8.sel, bus8.dout_valid, bus8.busy, bus8.frame_done,
            bus8.start_err, bus8.parity_err, out4, out3, out2, out1};
  endfunction

  function automatic logic [11:0] obs2();
    return {4'b0, bus2.dout, bus2.sel, bus2.dout_valid, bus2.busy, bus2.frame_done,
            bus2.start_err, bus2.parity_err};
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d);
    bus8.start  = s;
    bus8.ser_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic s, input logic d, input logic o, input logic [1:0] sl,
                          input logic v, input logic b, input logic dn, input logic se, input logic pe);
    vec_t r;
    r = '{start: s, ser: d, dout: o, sel: sl, valid: v, busy: b, done: dn, serr: se, perr: pe};
    vecs.push_back(r);
  endtask

  // Expands one frame into per-edge rows; err_row marks the edge carrying a stray start.
  task automatic push_frame(input logic [1:0] a, input logic [7:0] pl, input logic pb,
                            input logic idle_after, input int err_row);
    push_row(1'b1, a[1], 1'b0, cur_sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_row(err_row == 1, a[0], 1'b0, a, 1'b0, 1'b1, 1'b0, err_row == 1, 1'b0);
    cur_sel = a;
    for (int i = 0; i < 8; i++)
      push_row(err_row == 2 + i, pl[7-i], pl[7-i], a, 1'b1, 1'b1,
               (i == 7) && !PAR_EN, err_row == 2 + i, 1'b0);
`ifdef DEMUX_FRAME_PARITY_EN
    push_row(1'b0, pb, 1'b0, a, 1'b0, 1'b1, 1'b1, 1'b0, (^pl) ^ pb);
`endif
    if (idle_after)
      push_row(1'b0, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_vectors(input string tag);
    logic [3:0] dmx_exp;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].ser);
      dmx_exp = vecs[i].dout ? (4'b0001 << vecs[i].sel) : 4'b0000;
      checkOutput($sformatf("%s row %0d", tag, i), obs8(),
                  {vecs[i].dout, vecs[i].sel, vecs[i].valid, vecs[i].busy, vecs[i].done,
                   vecs[i].serr, vecs[i].perr, dmx_exp});
    end
    vecs.delete();
  endtask

  task automatic step2(input string name, input logic s, input logic d, input logic [7:0] exp);
    bus2.start  = s;
    bus2.ser_in = d;
    @(posedge clk);
    #1;
    checkOutput(name, obs2(), {4'b0, exp});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cur_sel = 2'b00;
    bus8.start = 1'b0; bus8.ser_in = 1'b0;
    bus2.start = 1'b0; bus2.ser_in = 1'b0;
    #12;
    checkOutput("reset dut8", obs8(), 12'h000);
    checkOutput("reset dut2", obs2(), 12'h000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, back-to-back pair, stray start, then parity good/bad frames
    push_frame(2'b10, 8'hB2, 1'b0, 1'b1, -1);
    push_frame(2'b00, 8'h5A, 1'b0, 1'b0, -1);
    push_frame(2'b11, 8'hC3, 1'b0, 1'b1, -1);
    push_frame(2'b01, 8'h3C, 1'b0, 1'b1, 4);
    push_frame(2'b10, 8'hB2, 1'b0, 1'b1, -1);
    push_frame(2'b10, 8'hB2, 1'b1, 1'b1, -1);
    run_vectors("frames");

    // Mid-payload reset: outputs clear immediately and no frame_done follows
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pre-reset state", obs8(), {1'b1, 2'b11, 1'b1, 1'b1, 3'b000, 4'b1000});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset clear", obs8(), 12'h000);
    @(posedge clk);
    #1;
    checkOutput("reset held", obs8(), 12'h000);
    rst_n = 1'b1;
    bus8.start = 1'b0;
    cur_sel = 2'b00;
    push_frame(2'b11, 8'h81, 1'b0, 1'b1, -1);
    run_vectors("post-reset");

    // Minimum payload length on the second instance
    step2("len2 start", 1'b1, 1'b0, {1'b0, 2'b00, 1'b0, 1'b1, 3'b000});
    step2("len2 addr",  1'b0, 1'b1, {1'b0, 2'b01, 1'b0, 1'b1, 3'b000});
    step2("len2 bit0",  1'b0, 1'b1, {1'b1, 2'b01, 1'b1, 1'b1, 3'b000});
    step2("len2 bit1",  1'b0, 1'b1, {1'b1, 2'b01, 1'b1, 1'b1, !PAR_EN, 2'b00});
`ifdef DEMUX_FRAME_PARITY_EN
    step2("len2 parity", 1'b0, 1'b0, {1'b0, 2'b01, 1'b0, 1'b1, 3'b100});
`endif
    step2("len2 idle",  1'b0, 1'b0, {1'b0, 2'b01, 1'b0, 1'b0, 3'b000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
